lsu_mem_stage: RTL and testbench

- Parametrised load/store memory stage between execute and write-back of the RV32I_Zicsr pipeline.
- Issues registered bus requests with a req/ack handshake and stalls upstream while a request is outstanding.
- Formats load data with byte/half/word (and double when XLEN=64) sign or zero extension, and generates store byte-enables.
- Detects misaligned accesses and passes non-memory ops through with one-cycle latency.

---
 rtl/lsu_mem_stage_pkg.sv | 31 +++
 rtl/lsu_mem_stage_if.sv | 17 +
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_mem_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage: opcodes, access sizes,
// FSM state type and funct3 legality helper.
package lsu_mem_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;
  localparam logic [6:0] I_OP = 7'b0010011;

  // funct3[1:0] is log2 of the access size in bytes
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} lsu_state_e;

  // Legal funct3 encodings; doubles and LWU exist only on a 64-bit datapath
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_st,
                                    input logic xlen64);
    case (f3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !is_st;
      3'b011:                 f3_legal = xlen64;
      3'b110:                 f3_legal = xlen64 && !is_st;
      default:                f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data bus between the LSU memory stage (master) and memory (slave).
interface lsu_mem_stage_if #(parameter int XLEN = 32) ();
  localparam int NB = XLEN / 8;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Load data formatter: picks the addressed byte/half/word/double out of the
// bus word and sign- or zero-extends it to XLEN.
module lsu_load_align #(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [OFFW-1:0] i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] sh, mask;
  logic            msb;

  // Shift the addressed lane down to bit 0, keep the access width, extend
  always_comb begin
    sh = i_rdata >> {i_off, 3'b000};
    case (i_funct3[1:0])
      2'd0:    begin mask = XLEN'(8'hFF);          msb = sh[7];  end
      2'd1:    begin mask = XLEN'(16'hFFFF);       msb = sh[15]; end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF);  msb = sh[31]; end
      default: begin mask = '1;                    msb = 1'b0;   end
    endcase
    o_data = (sh & mask) | ({XLEN{msb & ~i_funct3[2]}} & ~mask);
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage between execute and write-back. Issues one registered bus
// request at a time, stalls upstream while it is outstanding, formats load
// data, flags misaligned/illegal accesses and passes other ops through.
// Optional bus watchdog: define LSU_BUS_TIMEOUT_EN.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int XADDR   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_write,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  input  logic             i_stall,
  lsu_mem_stage_if.master  bus,
  output logic             o_wb_valid,
  output logic [XLEN-1:0]  o_pc,
  output logic [XADDR-1:0] o_rd_addr,
  output logic             o_rd_write,
  output logic [XLEN-1:0]  o_rd_data,
  output logic [6:0]       o_opcode,
  output logic             o_misalign,
  output logic             o_bus_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XADDR-1:0] rd_addr;
    logic             rd_write;
    logic [XLEN-1:0]  rd_data;
    logic [6:0]       opcode;
  } wb_t;

  lsu_state_e      state;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [NB-1:0]   mem_be;
  wb_t             wb_q, sk_q, hold_q, in_wb, res_ok, res_err;
  logic            wb_vld, sk_vld, misalign;
  logic [2:0]      h_f3;
  logic [OFFW-1:0] h_off;
  logic            h_ld;

  logic            is_ld, is_st, is_mem, bad, acc;
  logic [OFFW-1:0] off;
  logic [2:0]      amask;
  logic [7:0]      be_base;
  logic [NB-1:0]   be_w;
  logic [XLEN-1:0] ld_data;

  // A buffered result must reach write-back before a new instruction can
  // produce one, so a full skid register also holds off acceptance.
  assign o_ready = i_rst_n && (state == ST_IDLE) && !i_stall && !sk_vld;
  assign acc     = i_valid && o_ready;

  assign is_ld  = (i_opcode == L_OP);
  assign is_st  = (i_opcode == S_OP);
  assign is_mem = is_ld || is_st;
  assign off    = i_alu_result[OFFW-1:0];

  // Size-dependent alignment mask and base byte-enable pattern
  always_comb begin
    case (i_funct3[1:0])
      SZ_B:    begin amask = 3'd0; be_base = 8'h01; end
      SZ_H:    begin amask = 3'd1; be_base = 8'h03; end
      SZ_W:    begin amask = 3'd3; be_base = 8'h0F; end
      default: begin amask = 3'd7; be_base = 8'hFF; end
    endcase
  end

  assign bad  = !f3_legal(i_funct3, is_st, XLEN == 64) || (|(3'(off) & amask));
  assign be_w = NB'(be_base) << off;

  // Incoming instruction as it would appear on the write-back bundle
  always_comb begin
    in_wb.pc       = i_pc;
    in_wb.rd_addr  = i_rd_addr;
    in_wb.rd_write = i_rd_write && (i_rd_addr != '0) && !is_st && !(is_mem && bad);
    in_wb.rd_data  = is_mem ? '0 : i_alu_result;
    in_wb.opcode   = i_opcode;
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .i_rdata  (bus.mem_rdata),
    .i_off    (h_off),
    .i_funct3 (h_f3),
    .o_data   (ld_data)
  );

  // Completed bus result, and the no-data result used on a watchdog abort
  always_comb begin
    res_ok = hold_q;
    if (h_ld) res_ok.rd_data = ld_data;
    res_err          = hold_q;
    res_err.rd_write = 1'b0;
    res_err.rd_data  = '0;
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit, bus_err;
  assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT - 1));
  assign o_bus_err = bus_err;
`else
  // TIMEOUT is always positive, so this folds to a constant 0
  assign o_bus_err = (TIMEOUT < 0);
`endif

  // Stage FSM with all registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_q      <= '0;
      wb_vld    <= 1'b0;
      sk_q      <= '0;
      sk_vld    <= 1'b0;
      hold_q    <= '0;
      h_f3      <= '0;
      h_off     <= '0;
      h_ld      <= 1'b0;
      misalign  <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      tmo_cnt   <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      misalign <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      // write-back advances only when not stalled; skid drains first
      if (!i_stall) begin
        wb_vld <= sk_vld;
        if (sk_vld) wb_q <= sk_q;
        sk_vld <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (acc && !i_flush) begin
            if (!is_mem) begin
              wb_vld <= 1'b1;
              wb_q   <= in_wb;
            end else if (bad) begin
              misalign <= 1'b1;
              wb_vld   <= 1'b1;
              wb_q     <= in_wb;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_st;
              mem_addr  <= {i_alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_wdata <= i_rs2 << {off, 3'b000};
              mem_be    <= is_st ? be_w : '0;
              hold_q    <= in_wb;
              h_f3      <= i_funct3;
              h_off     <= off;
              h_ld      <= is_ld;
              state     <= ST_WAIT;
`ifdef LSU_BUS_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (bus.mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
            if (state == ST_WAIT && !i_flush) begin
              if (i_stall) begin sk_q <= res_ok; sk_vld <= 1'b1; end
              else         begin wb_q <= res_ok; wb_vld <= 1'b1; end
            end
          end
`ifdef LSU_BUS_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= ST_IDLE;
            if (state == ST_WAIT && !i_flush) begin
              if (i_stall) begin sk_q <= res_err; sk_vld <= 1'b1; end
              else         begin wb_q <= res_err; wb_vld <= 1'b1; end
            end
          end
`endif
          else begin
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + CW'(1);
`endif
            if (i_flush) state <= ST_DRAIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef LSU_BUS_TIMEOUT_EN
  // watchdog result path exists only with the timeout feature
  logic unused_res_err;
  assign unused_res_err = ^res_err;
`endif

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_be    = mem_be;

  assign o_wb_valid = wb_vld;
  assign o_pc       = wb_q.pc;
  assign o_rd_addr  = wb_q.rd_addr;
  assign o_rd_write = wb_q.rd_write;
  assign o_rd_data  = wb_q.rd_data;
  assign o_opcode   = wb_q.opcode;
  assign o_misalign = misalign;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized and directed bench for lsu_mem_stage (XLEN=32).
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  localparam int XLEN = 32, XADDR = 5;

  logic             i_clk = 1'b0, i_rst_n = 1'b0;
  logic             i_valid = 1'b0, o_ready;
  logic [6:0]       i_opcode = '0;
  logic [2:0]       i_funct3 = '0;
  logic [XLEN-1:0]  i_rs2 = '0, i_alu_result = '0, i_pc = '0;
  logic [XADDR-1:0] i_rd_addr = '0;
  logic             i_rd_write = 1'b0, i_flush = 1'b0, i_stall = 1'b0;
  logic             o_wb_valid, o_rd_write, o_misalign, o_bus_err;
  logic [XLEN-1:0]  o_pc, o_rd_data;
  logic [XADDR-1:0] o_rd_addr;
  logic [6:0]       o_opcode;
  int errs = 0, checks = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_stage_if #(.XLEN(XLEN)) bus ();

  lsu_mem_stage #(.XLEN(XLEN), .XADDR(XADDR), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_rs2(i_rs2),
    .i_alu_result(i_alu_result), .i_rd_addr(i_rd_addr), .i_rd_write(i_rd_write),
    .i_pc(i_pc), .i_flush(i_flush), .i_stall(i_stall), .bus(bus),
    .o_wb_valid(o_wb_valid), .o_pc(o_pc), .o_rd_addr(o_rd_addr),
    .o_rd_write(o_rd_write), .o_rd_data(o_rd_data), .o_opcode(o_opcode),
    .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] f3);
    longint v;
    int bits, off;
    off  = int'(a % 4);
    bits = 8 << f3[1:0];
    v = (longint'(rd) >> (8 * off)) % (longint'(1) << bits);
    if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic bit m_legal(input logic [2:0] f3, input bit st);
    if (st) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit m_aligned(input logic [31:0] a, input logic [2:0] f3);
    return (a % (32'd1 << f3[1:0])) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs2,
                       input logic [31:0] a, input logic [4:0] rd, input logic rdw,
                       input logic [31:0] pc, input logic fl);
    int n;
    n = 0;
    i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_rs2 = rs2; i_alu_result = a;
    i_rd_addr = rd; i_rd_write = rdw; i_pc = pc; i_flush = fl;
    while (!o_ready && n < 50) begin tick(); n++; end
    checks++;
    if (o_ready !== 1'b1) begin
      errs++; $display("FAIL issue_ready_timeout: o_ready=%b required 1", o_ready);
    end
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata);
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, o_wb_valid, o_misalign, o_bus_err, o_ready} !== '0) begin
      errs++; $display("FAIL reset_ctrl: got %b required 0",
        {bus.mem_req, bus.mem_we, bus.mem_be, o_wb_valid, o_misalign, o_bus_err, o_ready});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, o_pc, o_rd_data, o_rd_addr, o_opcode, o_rd_write} !== '0) begin
      errs++; $display("FAIL reset_data: got nonzero, required 0");
    end
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: o_ready=%b required 1", o_ready); end
  endtask

  task automatic test_lb();
    int low;
    issue(L_OP, 3'b000, 32'h0, 32'h0000_1003, 5'd5, 1'b1, 32'h100, 1'b0);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      errs++; $display("FAIL lb_req: req/we/addr=%b/%b/%h required 1/0/00001000",
        bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    low = 0;
    repeat (3) begin low += int'(!o_ready); tick(); end
    low += int'(!o_ready);
    ack(32'h80AB_CDEF);
    checks++;
    if (low != 4 || o_ready !== 1'b1) begin
      errs++; $display("FAIL lb_ready_low: cycles=%0d ready=%b required 4/1", low, o_ready);
    end
    checks++;
    if ({o_wb_valid, o_rd_write, o_rd_addr, o_rd_data, bus.mem_req} !== {1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0}) begin
      errs++; $display("FAIL lb_wb: vld=%b wr=%b rd=%0d data=%h req=%b required 1/1/5/ffffff80/0",
        o_wb_valid, o_rd_write, o_rd_addr, o_rd_data, bus.mem_req);
    end
  endtask

  task automatic test_sh();
    issue(S_OP, 3'b001, 32'h1234_5678, 32'h0000_2002, 5'd9, 1'b1, 32'h104, 1'b0);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !==
        {1'b1, 1'b1, 4'b1100, 32'h5678_0000, 32'h0000_2000}) begin
      errs++; $display("FAIL sh_req: we=%b be=%b wdata=%h addr=%h required 1/1100/56780000/00002000",
        bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_be, bus.mem_wdata} !== {1'b1, 4'b1100, 32'h5678_0000}) begin
      errs++; $display("FAIL sh_stable: req=%b be=%b wdata=%h", bus.mem_req, bus.mem_be, bus.mem_wdata);
    end
    ack(32'hFFFF_FFFF);
    checks++;
    if ({o_wb_valid, o_rd_write, o_pc} !== {1'b1, 1'b0, 32'h104}) begin
      errs++; $display("FAIL sh_wb: vld=%b wr=%b pc=%h required 1/0/104", o_wb_valid, o_rd_write, o_pc);
    end
  endtask

  task automatic test_misalign();
    issue(L_OP, 3'b010, 32'h0, 32'h0000_3001, 5'd4, 1'b1, 32'h108, 1'b0);
    checks++;
    if ({bus.mem_req, o_misalign, o_wb_valid, o_rd_write} !== 4'b0110) begin
      errs++; $display("FAIL misalign_pulse: req/mis/vld/wr=%b%b%b%b required 0110",
        bus.mem_req, o_misalign, o_wb_valid, o_rd_write);
    end
    tick();
    checks++;
    if ({bus.mem_req, o_misalign, o_wb_valid} !== 3'b000) begin
      errs++; $display("FAIL misalign_clear: req/mis/vld=%b%b%b required 000",
        bus.mem_req, o_misalign, o_wb_valid);
    end
  endtask

  task automatic test_flush_wait();
    issue(L_OP, 3'b101, 32'h0, 32'h0000_4002, 5'd6, 1'b1, 32'h10C, 1'b0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if ({bus.mem_req, o_ready, o_wb_valid} !== 3'b100) begin
      errs++; $display("FAIL flush_drain: req/rdy/vld=%b%b%b required 100", bus.mem_req, o_ready, o_wb_valid);
    end
    tick();
    ack(32'h1234_5678);
    checks++;
    if ({bus.mem_req, o_ready, o_wb_valid} !== 3'b010) begin
      errs++; $display("FAIL flush_discard: req/rdy/vld=%b%b%b required 010", bus.mem_req, o_ready, o_wb_valid);
    end
    issue(I_OP, 3'b000, 32'h0, 32'h0000_00AA, 5'd7, 1'b1, 32'h110, 1'b0);
    checks++;
    if ({o_wb_valid, o_rd_write, o_rd_data} !== {1'b1, 1'b1, 32'hAA}) begin
      errs++; $display("FAIL flush_next_addi: vld=%b wr=%b data=%h required 1/1/aa", o_wb_valid, o_rd_write, o_rd_data);
    end
  endtask

  task automatic test_ack_flush_same();
    issue(L_OP, 3'b010, 32'h0, 32'h0000_5004, 5'd8, 1'b1, 32'h114, 1'b0);
    i_flush = 1'b1;
    ack(32'hCAFE_F00D);
    i_flush = 1'b0;
    checks++;
    if ({bus.mem_req, o_ready, o_wb_valid} !== 3'b010) begin
      errs++; $display("FAIL ack_flush_same: req/rdy/vld=%b%b%b required 010", bus.mem_req, o_ready, o_wb_valid);
    end
  endtask

  task automatic test_idle_flush_stray_ack();
    issue(I_OP, 3'b000, 32'h0, 32'h0000_0033, 5'd3, 1'b1, 32'h118, 1'b1);
    checks++;
    if ({o_wb_valid, bus.mem_req} !== 2'b00) begin
      errs++; $display("FAIL idle_flush: vld/req=%b%b required 00", o_wb_valid, bus.mem_req);
    end
    ack(32'h1);
    checks++;
    if ({o_wb_valid, bus.mem_req, o_ready} !== 3'b001) begin
      errs++; $display("FAIL stray_ack: vld/req/rdy=%b%b%b required 001", o_wb_valid, bus.mem_req, o_ready);
    end
  endtask

  task automatic test_stall();
    issue(I_OP, 3'b000, 32'h0, 32'd5, 5'd3, 1'b1, 32'h120, 1'b0);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({o_wb_valid, o_rd_data, o_ready} !== {1'b1, 32'd5, 1'b0}) begin
        errs++; $display("FAIL stall_hold: vld=%b data=%h rdy=%b required 1/5/0", o_wb_valid, o_rd_data, o_ready);
      end
    end
    i_stall = 1'b0;
    tick();
    checks++;
    if (o_wb_valid !== 1'b0) begin errs++; $display("FAIL stall_release: vld=%b required 0", o_wb_valid); end
    // load completing under stall is buffered until the stall drops
    issue(L_OP, 3'b010, 32'h0, 32'h0000_6000, 5'd0, 1'b1, 32'h124, 1'b0);
    i_stall = 1'b1;
    ack(32'hDEAD_BEEF);
    tick();
    checks++;
    if ({bus.mem_req, o_wb_valid, o_ready} !== 3'b000) begin
      errs++; $display("FAIL skid_hold: req/vld/rdy=%b%b%b required 000", bus.mem_req, o_wb_valid, o_ready);
    end
    i_stall = 1'b0;
    tick();
    checks++;
    if ({o_wb_valid, o_rd_data, o_rd_write, o_pc} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h124}) begin
      errs++; $display("FAIL skid_drain: vld=%b data=%h wr=%b pc=%h required 1/deadbeef/0/124",
        o_wb_valid, o_rd_data, o_rd_write, o_pc);
    end
  endtask

  task automatic test_reset_mid();
    issue(S_OP, 3'b010, 32'h55, 32'h0000_7000, 5'd1, 1'b0, 32'h128, 1'b0);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, o_ready} !== 2'b00) begin
      errs++; $display("FAIL reset_mid: req/rdy=%b%b required 00", bus.mem_req, o_ready);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.mem_req, o_ready} !== 2'b01) begin
      errs++; $display("FAIL reset_mid_idle: req/rdy=%b%b required 01", bus.mem_req, o_ready);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [4];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, rs2, pc, rdata;
    logic [4:0]  rd;
    logic        rdw;
    bit          st, mem;
    int          d;
    ops[0] = L_OP; ops[1] = S_OP; ops[2] = I_OP; ops[3] = 7'b0110011;
    for (int t = 0; t < 60; t++) begin
      op = ops[$urandom_range(0, 3)];
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; rs2 = $urandom; pc = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(0, 31)); rdw = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 3);
      st = (op == S_OP); mem = (op == L_OP) || st;
      issue(op, f3, rs2, a, rd, rdw, pc, 1'b0);
      if (!mem) begin
        checks++;
        if ({o_wb_valid, o_rd_data, o_rd_write, o_pc, o_opcode, o_misalign, bus.mem_req} !==
            {1'b1, a, rdw && rd != 0, pc, op, 1'b0, 1'b0}) begin
          errs++; $display("FAIL rnd_alu[%0d]: vld=%b data=%h wr=%b required 1/%h/%b",
            t, o_wb_valid, o_rd_data, o_rd_write, a, rdw && rd != 0);
        end
      end else if (!m_legal(f3, st) || !m_aligned(a, f3)) begin
        checks++;
        if ({bus.mem_req, o_misalign, o_wb_valid, o_rd_write, o_pc} !== {4'b0110, pc}) begin
          errs++; $display("FAIL rnd_bad[%0d]: f3=%0d a=%h req/mis/vld/wr=%b%b%b%b required 0110",
            t, f3, a, bus.mem_req, o_misalign, o_wb_valid, o_rd_write);
        end
      end else begin
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, st, a - (a % 4)} ||
            (st && {bus.mem_be, bus.mem_wdata} !== {m_be(a, f3), rs2 << (8 * (a % 4))})) begin
          errs++; $display("FAIL rnd_req[%0d]: f3=%0d a=%h req=%b we=%b addr=%h be=%b wdata=%h",
            t, f3, a, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        repeat (d) tick();
        ack(rdata);
        checks++;
        if ({o_wb_valid, bus.mem_req, o_rd_write, o_pc} !== {1'b1, 1'b0, !st && rdw && rd != 0, pc} ||
            (!st && o_rd_data !== m_load(rdata, a, f3))) begin
          errs++; $display("FAIL rnd_wb[%0d]: f3=%0d a=%h rdata=%h vld=%b wr=%b data=%h required data %h",
            t, f3, a, rdata, o_wb_valid, o_rd_write, o_rd_data, m_load(rdata, a, f3));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(L_OP, 3'b010, 32'h0, 32'h0000_8000, 5'd2, 1'b1, 32'h130, 1'b0);
`ifdef LSU_BUS_TIMEOUT_EN
    n = 0;
    while (bus.mem_req && n < 30) begin n++; tick(); end
    checks++;
    if (n != 8 || {o_bus_err, o_wb_valid, o_rd_write} !== 3'b110) begin
      errs++; $display("FAIL timeout_fire: req cycles=%0d err/vld/wr=%b%b%b required 8/110",
        n, o_bus_err, o_wb_valid, o_rd_write);
    end
    tick();
    checks++;
    if ({o_bus_err, o_ready} !== 2'b01) begin
      errs++; $display("FAIL timeout_pulse: err/rdy=%b%b required 01", o_bus_err, o_ready);
    end
`else
    n = 0;
    repeat (20) begin tick(); n++; end
    checks++;
    if ({bus.mem_req, o_bus_err, o_ready} !== 3'b100) begin
      errs++; $display("FAIL no_timeout_wait: req/err/rdy=%b%b%b after %0d cycles required 100",
        bus.mem_req, o_bus_err, o_ready, n);
    end
    ack(32'h0000_0042);
    checks++;
    if ({o_wb_valid, o_rd_data, o_bus_err} !== {1'b1, 32'h42, 1'b0}) begin
      errs++; $display("FAIL no_timeout_ack: vld=%b data=%h err=%b required 1/42/0", o_wb_valid, o_rd_data, o_bus_err);
    end
`endif
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_flush_wait();
    test_ack_flush_same();
    test_idle_flush_stray_ack();
    test_stall();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
